// File: rtl/face_detect_div_pkg.sv
// Shared types and sizing helpers for the face_detect sequential signed divider.
package face_detect_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam int unsigned DIN0_WIDTH_DEF = 64;
   // Accept edge to done edge, in ce-enabled cycles, for the default dividend width.
   localparam int unsigned DIV_LATENCY    = DIN0_WIDTH_DEF + 1;

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/face_detect_sdiv_64s_32s_32_seq_core.sv
// Unsigned bit-serial restoring divide datapath: one quotient bit per enabled step.
module face_detect_sdiv_64s_32s_32_seq_core
   import face_detect_div_pkg::*;
#(
   parameter int unsigned din0_WIDTH = 64,
   parameter int unsigned din1_WIDTH = 32,
   parameter int unsigned dout_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  load,
   input  logic                  step,
   input  logic [din0_WIDTH-1:0] dividend,
   input  logic [din1_WIDTH-1:0] divisor,
   output logic [dout_WIDTH-1:0] quo,
   output logic [din1_WIDTH-1:0] rem,
   output logic                  last
);

   localparam int unsigned CntW = cnt_width(din0_WIDTH + 1);

   // Dividend bits leave at the top while quotient bits enter at the bottom.
   logic [din0_WIDTH-1:0] dq_q;
   logic [din1_WIDTH-1:0] rem_q;
   logic [din1_WIDTH-1:0] dvs_q;
   logic [CntW-1:0]       cnt_q;
   logic [din1_WIDTH:0]   shifted;
   logic [din1_WIDTH+1:0] diff;
   logic [din1_WIDTH-1:0] rem_d;
   logic                  fits;
   logic                  unused_diff_bit;

   // The stored remainder is always below the divisor, so only the shifted value needs the extra bit.
   always_comb begin
      shifted         = {rem_q, dq_q[din0_WIDTH-1]};
      diff            = {1'b0, shifted} - {2'b00, dvs_q};
      fits            = ~diff[din1_WIDTH+1];
      rem_d           = fits ? diff[din1_WIDTH-1:0] : shifted[din1_WIDTH-1:0];
      unused_diff_bit = diff[din1_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         dq_q  <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (ce) begin
         if (load) begin
            dq_q  <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
            cnt_q <= '0;
         end else if (step) begin
            dq_q  <= {dq_q[din0_WIDTH-2:0], fits};
            rem_q <= rem_d;
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign quo  = dq_q[dout_WIDTH-1:0];
   assign rem  = rem_q;
   assign last = (cnt_q == CntW'(din0_WIDTH - 1));

endmodule

// File: rtl/face_detect_sdiv_64s_32s_32_seq.sv
// Multi-cycle signed 64/32 divider with start/done handshake; sign handling and FSM live here.
module face_detect_sdiv_64s_32s_32_seq
   import face_detect_div_pkg::*;
#(
   parameter int unsigned din0_WIDTH = 64,
   parameter int unsigned din1_WIDTH = 32,
   parameter int unsigned dout_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  ready,
   output logic                  done,
   output logic [dout_WIDTH-1:0] quotient,
   output logic [dout_WIDTH-1:0] remainder
);

   state_t                state_q, state_d;
   logic                  load, step, last;
   logic                  sign_q, sign_r, div0;
   logic [dout_WIDTH-1:0] din0_lo_q;
   logic [dout_WIDTH-1:0] quo_mag;
   logic [din1_WIDTH-1:0] rem_mag;
   logic [din0_WIDTH-1:0] din0_abs;
   logic [din1_WIDTH-1:0] din1_abs;
   logic [dout_WIDTH-1:0] quotient_q, remainder_q;
   logic                  done_q;

   // abs(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
   assign din0_abs = din0[din0_WIDTH-1] ? -din0 : din0;
   assign din1_abs = din1[din1_WIDTH-1] ? -din1 : din1;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (last) state_d = FIX;
         end
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   face_detect_sdiv_64s_32s_32_seq_core #(
      .din0_WIDTH(din0_WIDTH),
      .din1_WIDTH(din1_WIDTH),
      .dout_WIDTH(dout_WIDTH)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .ce      (ce),
      .load    (load),
      .step    (step),
      .dividend(din0_abs),
      .divisor (din1_abs),
      .quo     (quo_mag),
      .rem     (rem_mag),
      .last    (last)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         div0        <= 1'b0;
         din0_lo_q   <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         done_q      <= 1'b0;
      end else if (ce) begin
         state_q <= state_d;
         done_q  <= (state_q == FIX);
         if (load) begin
            sign_q    <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
            sign_r    <= din0[din0_WIDTH-1];
            div0      <= (din1 == '0);
            din0_lo_q <= din0[dout_WIDTH-1:0];
         end
         if (state_q == FIX) begin
            if (div0) begin
               quotient_q  <= '1;
               remainder_q <= din0_lo_q;
            end else begin
               // Negating the low bits equals the low bits of the full negation.
               quotient_q  <= sign_q ? -quo_mag : quo_mag;
               remainder_q <= sign_r ? dout_WIDTH'(-rem_mag) : dout_WIDTH'(rem_mag);
            end
         end
      end
   end

   assign ready     = (state_q == IDLE);
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule
